// File: rtl/result_display_pkg.sv
// Shared types and 7-segment encodings for the result display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package result_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  localparam int unsigned BCD_W = 12;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/result_display_bin_to_bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle, NB_DATA+1 steps.
// done_o is high during the final step; bcd_o is valid from the following cycle.
module bin_to_bcd
  import result_display_pkg::*;
#(
  parameter int unsigned NB_DATA = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [NB_DATA:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int unsigned CW = $clog2(NB_DATA + 1);

  logic [NB_DATA:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= CW'(NB_DATA);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bin_q <= bin_q << 1;
      bcd_q <= (adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[NB_DATA]};
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_display.sv
// ALU result front panel: captures a signed result, converts |x| to BCD and
// scans sign + 3 digits onto a 4-digit common-anode display; LEDs mirror the raw value.
module result_display
  import result_display_pkg::*;
#(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [NB_DATA-1:0]   i_result,
  output logic                 o_busy,
  output logic [NB_DATA-1:0]   o_leds,
  output logic [NB_DIGITS-1:0] o_anodes,
  output logic [6:0]           o_segments
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] leds_q;
  logic [NB_DATA-1:0] pval_q, pval_d;
  logic               pend_q, pend_d;
  logic               sign_q, sign_d;
  logic               start;
  logic [NB_DATA-1:0] start_val;
  logic [NB_DATA:0]   ext, mag;

  logic               cvt_busy, cvt_done;
  logic [BCD_W-1:0]   cvt_bcd;

  logic               disp_neg_q;
  logic [BCD_W-1:0]   disp_bcd_q;

  logic [RW-1:0]        refresh_q;
  logic [1:0]           idx_q;
  logic [NB_DIGITS-1:0] an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           units, tens, hunds;

  // A load arriving in UPDATE is consumed directly, so back-to-back conversions have no gap.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    start_val = i_result;
    pend_d    = pend_q;
    pval_d    = pval_q;
    case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_load) begin
          pend_d = 1'b1;
          pval_d = i_result;
        end
        if (cvt_done) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        pend_d = 1'b0;
        if (i_load || pend_q) begin
          start     = 1'b1;
          start_val = i_load ? i_result : pval_q;
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sign_d = start ? start_val[NB_DATA-1] : sign_q;
  end

  // Magnitude is one bit wider so the most negative input converts correctly.
  assign ext = {start_val[NB_DATA-1], start_val};
  assign mag = ext[NB_DATA] ? (~ext + 1'b1) : ext;

  bin_to_bcd #(
    .NB_DATA(NB_DATA)
  ) u_bin_to_bcd (
    .clk_i  (i_clock),
    .rst_ni (i_reset),
    .start_i(start),
    .bin_i  (mag),
    .busy_o (cvt_busy),
    .done_o (cvt_done),
    .bcd_o  (cvt_bcd)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      leds_q     <= '0;
      pend_q     <= 1'b0;
      pval_q     <= '0;
      sign_q     <= 1'b0;
      disp_neg_q <= 1'b0;
      disp_bcd_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      sign_q  <= sign_d;
      if (i_load) begin
        leds_q <= i_result;
      end
      if (state_q == ST_UPDATE) begin
        disp_neg_q <= sign_q;
        disp_bcd_q <= cvt_bcd;
      end
    end
  end

  assign units = disp_bcd_q[3:0];
  assign tens  = disp_bcd_q[7:4];
  assign hunds = disp_bcd_q[11:8];

  always_comb begin
    an_d        = '1;
    an_d[idx_q] = 1'b0;
    case (idx_q)
      2'd0:    seg_d = bcd_to_seg(units);
      2'd1:    seg_d = (tens == 4'd0 && hunds == 4'd0) ? SEG_BLANK : bcd_to_seg(tens);
      2'd2:    seg_d = (hunds == 4'd0) ? SEG_BLANK : bcd_to_seg(hunds);
      default: seg_d = disp_neg_q ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
    end else begin
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        idx_q     <= idx_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign o_busy     = cvt_busy || (state_q == ST_UPDATE);
  assign o_leds     = leds_q;
  assign o_anodes   = an_q;
  assign o_segments = seg_q;

endmodule

// File: tb/tb_result_display.sv
// Randomised scoreboard bench for result_display with a fast refresh divider.
module tb_result_display;

  localparam int NB   = 8;
  localparam int RD   = 4;
  localparam int CONV = NB + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [NB-1:0] res = '0;
  logic          busy;
  logic [NB-1:0] leds;
  logic [3:0]    an;
  logic [6:0]    seg;

  result_display #(
    .NB_DATA    (NB),
    .NB_DIGITS  (4),
    .REFRESH_DIV(RD)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_load    (load),
    .i_result  (res),
    .o_busy    (busy),
    .o_leds    (leds),
    .o_anodes  (an),
    .o_segments(seg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state, advanced once per clock edge by step()
  int            q[$];
  int            tcyc = 0;
  int            m_end = 0;
  bit            m_pend = 1'b0;
  int            m_pv = 0;
  logic [NB-1:0] leds_exp = '0;

  // monitor state
  int mon_bc = 0;
  int mon_cur = 0;
  int mon_nxt = 0;
  int mon_apply = 0;
  int mon_k = 0;
  logic [3:0] ea;

  string dig_lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  function automatic logic [6:0] lit(input string s);
    logic [6:0] r;
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) begin
      r[int'(s[i]) - 97] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int k);
    int mag, h, te, u;
    mag = (v < 0) ? -v : v;
    h   = mag / 100;
    te  = (mag / 10) % 10;
    u   = mag % 10;
    case (k)
      0:       return lit(dig_lit[u]);
      1:       return (h == 0 && te == 0) ? 7'h7F : lit(dig_lit[te]);
      2:       return (h == 0) ? 7'h7F : lit(dig_lit[h]);
      default: return (v < 0) ? lit("g") : 7'h7F;
    endcase
  endfunction

  task automatic step(input bit l, input logic [NB-1:0] v);
    int t;
    load = l;
    res  = v;
    @(posedge clk);
    t = tcyc;
    tcyc++;
    if (l) begin
      leds_exp = v;
      if (t >= m_end) begin
        q.push_back(int'($signed(v)));
        m_end  = t + CONV;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
        m_pv   = int'($signed(v));
      end
    end else if (m_pend && t == m_end) begin
      q.push_back(m_pv);
      m_end  = t + CONV;
      m_pend = 1'b0;
    end
    #1;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  task automatic model_clear();
    q.delete();
    tcyc     = 0;
    m_end    = 0;
    m_pend   = 1'b0;
    leds_exp = '0;
  endtask

  // Monitor: each run of CONV busy cycles completes one conversion.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_bc    = 0;
        mon_cur   = 0;
        mon_apply = 0;
      end else begin
        if (mon_apply > 0) begin
          mon_apply--;
          if (mon_apply == 0) mon_cur = mon_nxt;
        end
        check("busy", int'(busy), int'(tcyc > 0 && (tcyc - 1) < m_end));
        check("leds", int'(leds), int'(leds_exp));
        if (tcyc == 0) begin
          check("anodes_pre", int'(an), 'hF);
          check("seg_pre", int'(seg), 'h7F);
        end else begin
          mon_k = ((tcyc - 1) / RD) % 4;
          ea = 4'hF;
          ea[mon_k] = 1'b0;
          check("anodes", int'(an), int'(ea));
          check($sformatf("seg_d%0d", mon_k), int'(seg), int'(exp_seg(mon_cur, mon_k)));
        end
        if (busy) mon_bc++;
        else mon_bc = 0;
        if (mon_bc == CONV) begin
          mon_bc = 0;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: conversion finished with no expected value queued");
          end else begin
            mon_nxt   = q.pop_front();
            mon_apply = 2;
          end
        end
      end
    end
  end

  initial begin
    logic [NB-1:0] fixed [8];
    fixed = '{8'd123, 8'h80, 8'hF9, 8'd0, 8'd100, 8'h7F, 8'hFF, 8'd10};

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_leds", int'(leds), 0);
    check("rst_anodes", int'(an), 'hF);
    check("rst_seg", int'(seg), 'h7F);
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;

    idle(20);
    foreach (fixed[i]) begin
      step(1'b1, fixed[i]);
      idle(30);
    end

    // loads while busy: last one wins, middle one never shown
    step(1'b1, 8'd5);
    idle(2);
    step(1'b1, 8'd42);
    idle(2);
    step(1'b1, 8'd99);
    idle(40);

    // load landing exactly on the update cycle
    step(1'b1, 8'd10);
    idle(CONV - 1);
    step(1'b1, 8'd20);
    idle(30);

    // asynchronous reset in the middle of a conversion
    step(1'b1, 8'd77);
    idle(4);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("arst_anodes", int'(an), 'hF);
    check("arst_seg", int'(seg), 'h7F);
    check("arst_busy", int'(busy), 0);
    check("arst_leds", int'(leds), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(30);

    repeat (400) step($urandom_range(0, 4) == 0, NB'($urandom));
    idle(40);

    check("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
